// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants, FSM state type and round-robin pick for router arbiters
package router_pkg;

  localparam int N_PORTS = 16;
  localparam int ADDR_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns {found, idx}: first set bit of req searching ptr+1, ptr+2, ... with wrap.
  function automatic logic [ADDR_W:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [ADDR_W-1:0]  ptr);
    logic              found;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = ptr + ADDR_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// rtl/router_out_arbiter_if.sv - request lanes, output pins and grant/busy of one router output port
interface router_out_arbiter_if;
  import router_pkg::*;

  logic [N_PORTS-1:0] req_frame_n;
  logic [N_PORTS-1:0] req_valid_n;
  logic [N_PORTS-1:0] req_din;
  logic [N_PORTS-1:0] busy;
  logic [N_PORTS-1:0] grant;
  logic               frameo_n;
  logic               valido_n;
  logic               dout;

  modport master (
    output req_frame_n, req_valid_n, req_din,
    input  frameo_n, valido_n, dout, busy, grant
  );

  modport slave (
    input  req_frame_n, req_valid_n, req_din,
    output frameo_n, valido_n, dout, busy, grant
  );

endinterface

// File: rtl/rr_arb16.sv
// rtl/rr_arb16.sv - combinational 16-way round-robin search starting after the pointer
module rr_arb16
  import router_pkg::*;
(
  input  logic [N_PORTS-1:0] i_req,
  input  logic [ADDR_W-1:0]  i_ptr,
  output logic               o_found,
  output logic [ADDR_W-1:0]  o_idx
);

  logic [ADDR_W:0] w_pick;

  assign w_pick  = rr_pick(i_req, i_ptr);
  assign o_found = w_pick[ADDR_W];
  assign o_idx   = w_pick[ADDR_W-1:0];

endmodule

// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - per-output-port round-robin arbiter forwarding the winner's serial stream
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int N_IN         = 16,
  parameter int IDLE_TIMEOUT = 64,
  parameter int TMR_W        = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  router_out_arbiter_if.slave  bus
);

  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(IDLE_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_gnt_id;
  logic [ADDR_W-1:0] w_gnt_nxt;
  logic [ADDR_W-1:0] r_rr_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [ADDR_W-1:0] w_idx;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic              r_frameo_n;
  logic              r_valido_n;
  logic              r_dout;
  logic              w_frameo_nxt;
  logic              w_valido_nxt;
  logic              w_dout_nxt;
  logic              w_found;
  logic              w_g_frame_n;
  logic              w_g_valid_n;
  logic              w_g_din;
  logic              w_quiet;
  logic              w_tmo;
  logic [N_IN-1:0]   w_req;
  logic [N_IN-1:0]   w_grant;

  assign w_req   = ~bus.req_frame_n;
  assign w_grant = (r_state == GRANT) ? (N_IN'(1) << r_gnt_id) : '0;

  assign bus.busy     = w_req & ~w_grant;
  assign bus.grant    = w_grant;
  assign bus.frameo_n = r_frameo_n;
  assign bus.valido_n = r_valido_n;
  assign bus.dout     = r_dout;

  rr_arb16 u_rr_arb16 (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_g_frame_n = bus.req_frame_n[r_gnt_id];
  assign w_g_valid_n = bus.req_valid_n[r_gnt_id];
  assign w_g_din     = bus.req_din[r_gnt_id];

  // A quiet cycle is mid-packet with no valid bit; the 64th in a row forces release.
  assign w_quiet = ~w_g_frame_n & w_g_valid_n;
  assign w_tmo   = w_quiet & (r_tmr == TMO_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt_id;
    w_ptr_nxt    = r_rr_ptr;
    w_tmr_nxt    = r_tmr;
    w_frameo_nxt = 1'b1;
    w_valido_nxt = 1'b1;
    w_dout_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_idx;
          w_ptr_nxt   = w_idx;
          w_tmr_nxt   = '0;
        end
      end
      GRANT: begin
        if (w_tmo) begin
          // rr_ptr already holds the offender, so the next search starts past it.
          w_state_nxt = IDLE;
          w_tmr_nxt   = '0;
        end else begin
          w_frameo_nxt = w_g_frame_n;
          w_valido_nxt = w_g_valid_n;
          w_dout_nxt   = w_g_din;
          if (w_g_frame_n) begin
            w_state_nxt = IDLE;
            w_tmr_nxt   = '0;
          end else if (w_g_valid_n) begin
            w_tmr_nxt = r_tmr + TMR_W'(1);
          end else begin
            w_tmr_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_gnt_id   <= '0;
      r_rr_ptr   <= '1;
      r_tmr      <= '0;
      r_frameo_n <= 1'b1;
      r_valido_n <= 1'b1;
      r_dout     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_id   <= w_gnt_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_tmr      <= w_tmr_nxt;
      r_frameo_n <= w_frameo_nxt;
      r_valido_n <= w_valido_nxt;
      r_dout     <= w_dout_nxt;
    end
  end

endmodule
